// File: rtl/mux_lut_pipe_if.sv
// Valid/ready operand and result bus of the pipelined mux-tree LUT.
// The master side produces operands and consumes results; the slave side is the LUT.
interface mux_lut_pipe_if #(
  parameter int SEL_W = 2
);
  logic             in_valid;
  logic             in_ready;
  logic [SEL_W-1:0] in_sel;
  logic             out_valid;
  logic             out_ready;
  logic             out_y;

  modport master (
    output in_valid, in_sel, out_ready,
    input  in_ready, out_valid, out_y
  );

  modport slave (
    input  in_valid, in_sel, out_ready,
    output in_ready, out_valid, out_y
  );
endinterface

// File: rtl/mux_lut_pipe.sv
// Run-time programmable SEL_W-input logic function as a pipelined tree of 2:1 muxes.
// Each stage halves the candidate vector by one select bit; valid/ready on both sides.
module mux_lut_pipe #(
  parameter int                    SEL_W      = 2,
  parameter logic [2**SEL_W-1:0]   INIT_TABLE = {{(2**SEL_W-1){1'b1}}, 1'b0}
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_we,
  input  logic [2**SEL_W-1:0] cfg_table,
  mux_lut_pipe_if.slave       bus,
  output logic [2**SEL_W-1:0] table_q
);

  localparam int TW = 2**SEL_W;

  // Every stage keeps a full-width vector and the full select word; stage k only
  // consumes the low TW>>k bits and select bit k, which keeps the stages uniform.
  logic [SEL_W-1:0] valid_q, valid_d;
  logic [TW-1:0]    data_q [SEL_W];
  logic [TW-1:0]    data_d [SEL_W];
  logic [SEL_W-1:0] sel_q  [SEL_W];
  logic [SEL_W-1:0] sel_d  [SEL_W];
  logic [TW-1:0]    table_d;

  logic [SEL_W:0]   adv;
  logic             src_v [SEL_W];
  logic [TW-1:0]    src_d [SEL_W];
  logic [SEL_W-1:0] src_s [SEL_W];

  function automatic logic [TW-1:0] halve(input logic [TW-1:0] v, input logic s);
    logic [TW-1:0] r;
    r = '0;
    for (int j = 0; j < TW/2; j++) r[j] = s ? v[2*j+1] : v[2*j];
    return r;
  endfunction

  // A stage may advance when it is empty or everything downstream of it advances.
  always_comb begin
    logic a;
    a          = bus.out_ready;
    adv        = '0;
    adv[SEL_W] = bus.out_ready;
    for (int k = SEL_W-1; k >= 0; k--) begin
      a      = !valid_q[k] | a;
      adv[k] = a;
    end
  end

  always_comb begin
    src_v[0] = bus.in_valid;
    src_d[0] = table_q;
    src_s[0] = bus.in_sel;
    for (int k = 1; k < SEL_W; k++) begin
      src_v[k] = valid_q[k-1];
      src_d[k] = data_q[k-1];
      src_s[k] = sel_q[k-1];
    end
  end

  // NOTE: every output of a combinational block gets a default before any branch,
  // otherwise the unassigned paths infer latches.
  always_comb begin
    table_d = cfg_we ? cfg_table : table_q;
    valid_d = valid_q;
    data_d  = data_q;
    sel_d   = sel_q;
    for (int k = 0; k < SEL_W; k++) begin
      if (adv[k]) begin
        valid_d[k] = src_v[k];
        if (src_v[k]) begin
          data_d[k] = halve(src_d[k], src_s[k][k]);
          sel_d[k]  = src_s[k];
        end
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops sample the
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      table_q <= INIT_TABLE;
      // NOTE: the pipeline data is reset too, because out_y must read 0 after reset;
      // this is a handful of flops, not a RAM, so the reset costs nothing structural.
      for (int k = 0; k < SEL_W; k++) begin
        data_q[k] <= '0;
        sel_q[k]  <= '0;
      end
    end else begin
      valid_q <= valid_d;
      table_q <= table_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
    end
  end

  assign bus.in_ready  = adv[0];
  assign bus.out_valid = valid_q[SEL_W-1];
  assign bus.out_y     = data_q[SEL_W-1][0];

endmodule
